// File: rtl/reg_feeder_if.sv
// Handshake bundle between an upstream producer, the feeder, and the
// downstream register it loads.
interface reg_feeder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             stall;
    logic [WIDTH-1:0] d;
    logic             enable;

    modport master (
        output in_data, in_valid, stall,
        input  in_ready, d, enable
    );

    modport slave (
        input  in_data, in_valid, stall,
        output in_ready, d, enable
    );
endinterface

// File: rtl/reg_feeder.sv
// Small in-order queue that feeds a downstream register one word per cycle,
// presenting each word on d with a one-cycle enable strobe.
module reg_feeder #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    reg_feeder_if.slave            bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push;
    logic             pop;

    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    // A pop in the same cycle does not free space for a push while full.
    assign bus.in_ready = !full && !reset;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = !empty && !bus.stall && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            bus.d      <= '0;
            bus.enable <= 1'b0;
        end else begin
            if (push) begin
                mem[wptr] <= bus.in_data;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                bus.d      <= mem[rptr];
                bus.enable <= 1'b1;
                rptr       <= rptr + 1'b1;
            end else begin
                bus.enable <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_feeder.sv
// Directed self-checking bench for reg_feeder (WIDTH=32, DEPTH=4).
module tb_reg_feeder;
    localparam int W = 32;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   count;
    logic         empty;
    logic         full;
    int           checks = 0;
    int           errors = 0;

    reg_feeder_if #(.WIDTH(W)) bus ();

    reg_feeder #(.WIDTH(W), .DEPTH(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.stall = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 32'hDEAD_BEEF;
        bus.stall = 1'b0;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_during got=%0b exp=0", bus.in_ready);
        end
        reset = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got count=%0d empty=%0b full=%0b rdy=%0b exp 0 1 0 1",
                     count, empty, full, bus.in_ready);
        end
        checks++;
        if (bus.d !== 32'd0 || bus.enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got d=%0d en=%0b exp d=0 en=0", bus.d, bus.enable);
        end
    endtask

    task automatic test_stream;
        logic [W-1:0] vals [4];
        vals[0] = 15; vals[1] = 20; vals[2] = 25; vals[3] = 30;
        bus.stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                bus.in_valid = 1'b1;
                bus.in_data = vals[i];
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            checks++;
            if (count > 3'd1) begin
                errors++;
                $display("FAIL stream_count i=%0d got=%0d exp<=1", i, count);
            end
            checks++;
            if (i == 0) begin
                if (bus.enable !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_latency got en=%0b exp=0", bus.enable);
                end
            end else if (bus.enable !== 1'b1 || bus.d !== vals[i-1]) begin
                errors++;
                $display("FAIL stream_out i=%0d got d=%0d en=%0b exp d=%0d en=1",
                         i, bus.d, bus.enable, vals[i-1]);
            end
        end
        tick();
        checks++;
        if (bus.enable !== 1'b0 || empty !== 1'b1 || bus.d !== 32'd30) begin
            errors++;
            $display("FAIL stream_idle got en=%0b empty=%0b d=%0d exp 0 1 30",
                     bus.enable, empty, bus.d);
        end
    endtask

    task automatic test_fill_stall;
        bus.stall = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.in_data = W'(i);
            tick();
            checks++;
            if (bus.enable !== 1'b0) begin
                errors++;
                $display("FAIL stall_enable i=%0d got=%0b exp=0", i, bus.enable);
            end
        end
        #1;
        checks++;
        if (count !== 3'd4 || full !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_full got count=%0d full=%0b rdy=%0b exp 4 1 0",
                     count, full, bus.in_ready);
        end
        checks++;
        if (bus.d !== 32'd30) begin
            errors++;
            $display("FAIL stall_d_hold got=%0d exp=30", bus.d);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_drain;
        bus.stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (bus.enable !== 1'b1 || bus.d !== W'(i)) begin
                errors++;
                $display("FAIL drain_out i=%0d got d=%0d en=%0b exp d=%0d en=1",
                         i, bus.d, bus.enable, i);
            end
        end
        checks++;
        if (empty !== 1'b1 || bus.in_ready !== 1'b1 || count !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty got empty=%0b rdy=%0b count=%0d exp 1 1 0",
                     empty, bus.in_ready, count);
        end
        tick();
        checks++;
        if (bus.enable !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle_en got=%0b exp=0", bus.enable);
        end
    endtask

    task automatic test_full_pop;
        bus.stall = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_data = W'(40 + i);
            tick();
        end
        bus.stall = 1'b0;
        bus.in_data = 32'd99;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fullpop_ready got=%0b exp=0", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (count !== 3'd3 || bus.d !== 32'd41 || bus.enable !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_edge got count=%0d d=%0d en=%0b exp 3 41 1",
                     count, bus.d, bus.enable);
        end
        for (int i = 2; i <= 4; i++) begin
            tick();
            checks++;
            if (bus.d !== W'(40 + i) || bus.enable !== 1'b1) begin
                errors++;
                $display("FAIL fullpop_drain i=%0d got d=%0d en=%0b exp d=%0d en=1",
                         i, bus.d, bus.enable, 40 + i);
            end
        end
        tick();
        checks++;
        if (bus.enable !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_no99 got en=%0b empty=%0b d=%0d exp en=0 empty=1",
                     bus.enable, empty, bus.d);
        end
    endtask

    task automatic test_back_to_back;
        bus.stall = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 32'd50;
        tick();
        bus.in_data = 32'd60;
        tick();
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL b2b_setup got count=%0d exp=2", count);
        end
        bus.stall = 1'b0;
        bus.in_data = 32'd70;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (count !== 3'd2 || bus.d !== 32'd50 || bus.enable !== 1'b1) begin
            errors++;
            $display("FAIL b2b_simul got count=%0d d=%0d en=%0b exp 2 50 1",
                     count, bus.d, bus.enable);
        end
        tick();
        checks++;
        if (bus.d !== 32'd60 || count !== 3'd1) begin
            errors++;
            $display("FAIL b2b_second got d=%0d count=%0d exp 60 1", bus.d, count);
        end
        tick();
        checks++;
        if (bus.d !== 32'd70 || bus.enable !== 1'b1 || count !== 3'd0) begin
            errors++;
            $display("FAIL b2b_third got d=%0d en=%0b count=%0d exp 70 1 0",
                     bus.d, bus.enable, count);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        bus.stall = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                bus.in_valid = 1'b1;
                bus.in_data = W'(100 + i);
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            if (i > 0) begin
                checks++;
                if (bus.d !== W'(99 + i) || bus.enable !== 1'b1 || count > 3'd1) begin
                    errors++;
                    $display("FAIL wrap_out i=%0d got d=%0d en=%0b count=%0d exp d=%0d en=1",
                             i, bus.d, bus.enable, count, 99 + i);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        bus.stall = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 7; i <= 9; i++) begin
            bus.in_data = W'(i);
            tick();
        end
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL rstmid_setup got count=%0d exp=3", count);
        end
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.in_data = 32'd77;
        tick();
        checks++;
        if (count !== 3'd0 || bus.enable !== 1'b0 || bus.d !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_clear got count=%0d en=%0b d=%0d exp 0 0 0",
                     count, bus.enable, bus.d);
        end
        reset = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.enable !== 1'b0 || bus.d !== 32'd0 || empty !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_after i=%0d got en=%0b d=%0d empty=%0b exp 0 0 1",
                         i, bus.enable, bus.d, empty);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.stall = 1'b0;
        test_reset();
        test_stream();
        test_fill_stall();
        test_drain();
        test_full_pop();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_feeder.md
REG_FEEDER -- requirements
Module: reg_feeder

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  WIDTH  word offered by upstream producer.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  feeder accepts a word this cycle.
REQ-008 stall  input  1  downstream register cannot take a word this cycle.
REQ-009 d  output  WIDTH  data to downstream register d input.
REQ-010 enable  output  1  one-cycle load strobe to downstream register enable input.
REQ-011 count  output  $clog2(DEPTH)+1  number of queued words.
REQ-012 empty  output  1  count == 0.
REQ-013 full  output  1  count == DEPTH.

Function
REQ-014 Push SHALL occur on a rising edge when in_valid && in_ready; in_data is written at the write pointer.
REQ-015 in_ready SHALL be combinational: !full && !reset.
REQ-016 Pop SHALL occur on a rising edge when !empty && !stall && !reset; the head word moves to d.
REQ-017 d and enable SHALL be registered outputs: on pop, d <= head word, enable <= 1; otherwise enable <= 0 and d holds its last value.
REQ-018 Latency: a word pushed at edge N into an empty queue with stall low SHALL appear on d with enable=1 after edge N+1; no combinational bypass.
REQ-019 Words SHALL leave in arrival order; at most one push and one pop per cycle.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and both SHALL take effect.
REQ-021 When full, in_ready SHALL be 0 even if a pop occurs in the same cycle; no push that cycle.
REQ-022 When empty, enable SHALL be 0 regardless of stall.
REQ-023 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-024 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-025 stall high SHALL hold the queue contents and d; pushes continue while not full.
REQ-026 in_data SHALL be ignored when in_valid is 0 or in_ready is 0.

Reset
REQ-027 While reset is high at a rising edge: count=0, read/write pointers=0, d=0, enable=0.
REQ-028 Reset SHALL discard all queued words; no push or pop occurs on a reset edge.
REQ-029 After reset deasserts: empty=1, full=0, in_ready=1; storage contents need not be cleared.
REQ-030 Reset asserted mid-operation SHALL take priority over simultaneous push/pop.

Verification
REQ-031 Push 15,20,25,30 on consecutive cycles, stall=0 -> d=15,20,25,30 each with enable=1 one cycle after its push; enable=0 afterwards; count never exceeds 1.
REQ-032 stall=1, offer 5 words 1..5 -> first 4 accepted, count=4, full=1, in_ready=0, word 5 held by producer, enable stays 0.
REQ-033 From REQ-032 state, drop stall -> d=1,2,3,4 on 4 consecutive cycles with enable=1; then empty=1, in_ready=1.
REQ-034 count=2, push and pop in same cycle -> count stays 2, popped word is the oldest, pushed word emerges after the remaining one.
REQ-035 Continuous push/pop of 10 words 100..109 with DEPTH=4 -> pointers wrap twice, output order 100..109 exact.
REQ-036 count=3, assert reset for one cycle with in_valid=1 -> count=0, enable=0, d=0, queued words never appear on d.
